// File: rtl/bit_packer_pkg.sv
// rtl/bit_packer_pkg.sv - shared pack-order constants and width helpers for bit_packer
package bit_packer_pkg;

  localparam int PACK_LSB = 0;
  localparam int PACK_MSB = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  function automatic int max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bp_mask_shift.sv
// rtl/bp_mask_shift.sv - masks a fragment to its valid bits and aligns it behind the retained bits
module bp_mask_shift
  import bit_packer_pkg::*;
#(
  parameter int IN_W      = 64,
  parameter int IB_W      = 7,
  parameter int ACC_W     = 128,
  parameter int CNT_W     = 8,
  parameter int MSB_FIRST = PACK_LSB
) (
  input  logic [IN_W-1:0]  in_data,
  input  logic [IB_W-1:0]  in_bits,
  input  logic [CNT_W-1:0] fill_after_drain,
  output logic [ACC_W-1:0] insert_vec
);

  logic [CNT_W-1:0] bits_ext;
  logic [CNT_W-1:0] shift;
  logic [ACC_W-1:0] mask;
  logic [ACC_W-1:0] data_ext;

  always_comb begin
    bits_ext = CNT_W'(in_bits);
    mask     = ~({ACC_W{1'b1}} << bits_ext);
    data_ext = ACC_W'(in_data) & mask;
    // MSB-first keeps the message packed against the top of the accumulator.
    if (MSB_FIRST == PACK_MSB) shift = CNT_W'(ACC_W) - fill_after_drain - bits_ext;
    else                       shift = fill_after_drain;
    insert_vec = data_ext << shift;
  end

endmodule

// File: rtl/bit_packer.sv
// rtl/bit_packer.sv - packs 0..IN_W-bit fragments into dense OUT_W-bit words with flush on in_last
module bit_packer
  import bit_packer_pkg::*;
#(
  parameter int IN_W      = 64,
  parameter int OUT_W     = 64,
  parameter int MSB_FIRST = PACK_LSB
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [IN_W-1:0]              in_data,
  input  logic [clog2(IN_W+1)-1:0]     in_bits,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic [OUT_W-1:0]             out_data,
  output logic [clog2(OUT_W+1)-1:0]    out_bits,
  output logic                         out_last,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int IB_W  = clog2(IN_W + 1);
  localparam int OB_W  = clog2(OUT_W + 1);
  localparam int ACC_W = max(IN_W, OUT_W) + IN_W;
  localparam int CNT_W = clog2(ACC_W + 1);

  typedef enum logic {ST_IDLE, ST_FLUSH} state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_drain, insert_vec;
  logic [CNT_W-1:0] fill_q, fill_d, fill_drain, consumed;
  logic [IB_W-1:0]  bits_eff;
  logic [OUT_W-1:0] word;
  logic             word_full, flush_pend, in_fire, out_fire;

  always_comb begin
    bits_eff   = (in_bits > IB_W'(IN_W)) ? IB_W'(IN_W) : in_bits;
    word_full  = (fill_q >= CNT_W'(OUT_W));
    flush_pend = (state_q == ST_FLUSH);
    out_valid  = word_full || flush_pend;
    out_last   = flush_pend && (fill_q <= CNT_W'(OUT_W));
    in_ready   = !rst && !flush_pend && (!word_full || out_ready);
    in_fire    = in_valid && in_ready;
    out_fire   = out_valid && out_ready;
    word       = (MSB_FIRST == PACK_MSB) ? acc_q[ACC_W-1 -: OUT_W] : acc_q[OUT_W-1:0];
    out_data   = out_valid ? word : '0;
    if (!out_valid)     out_bits = '0;
    else if (word_full) out_bits = OB_W'(OUT_W);
    else                out_bits = OB_W'(fill_q);
  end

  // Drain happens before append so a same-cycle fragment lands behind what remains.
  always_comb begin
    consumed = '0;
    if (out_fire) consumed = word_full ? CNT_W'(OUT_W) : fill_q;
    fill_drain = fill_q - consumed;
    acc_drain  = (MSB_FIRST == PACK_MSB) ? (acc_q << consumed) : (acc_q >> consumed);
  end

  bp_mask_shift #(
    .IN_W      (IN_W),
    .IB_W      (IB_W),
    .ACC_W     (ACC_W),
    .CNT_W     (CNT_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_mask_shift (
    .in_data          (in_data),
    .in_bits          (bits_eff),
    .fill_after_drain (fill_drain),
    .insert_vec       (insert_vec)
  );

  always_comb begin
    acc_d   = acc_drain;
    fill_d  = fill_drain;
    state_d = state_q;
    if (in_fire) begin
      acc_d  = acc_drain | insert_vec;
      fill_d = fill_drain + CNT_W'(bits_eff);
      if (in_last) state_d = ST_FLUSH;
    end
    if (out_fire && out_last) begin
      acc_d   = '0;
      fill_d  = '0;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
    end
  end

endmodule

// File: tb/tb_bit_packer.sv
// tb/tb_bit_packer.sv - scoreboard bench for bit_packer: 64/64 LSB-first and 8/32 MSB-first instances
module tb_bit_packer;

  typedef struct {
    logic [127:0] data;
    int           bits;
    bit           last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [63:0] in_data0, out_data0;
  logic [6:0]  in_bits0, out_bits0;
  logic        in_valid0, in_last0, in_ready0, out_last0, out_valid0, out_ready0;
  logic [7:0]  in_data1;
  logic [3:0]  in_bits1;
  logic [31:0] out_data1;
  logic [5:0]  out_bits1;
  logic        in_valid1, in_last1, in_ready1, out_last1, out_valid1, out_ready1;

  bit_packer #(.IN_W(64), .OUT_W(64), .MSB_FIRST(0)) u0 (
    .clk(clk), .rst(rst), .in_data(in_data0), .in_bits(in_bits0), .in_valid(in_valid0),
    .in_last(in_last0), .in_ready(in_ready0), .out_data(out_data0), .out_bits(out_bits0),
    .out_last(out_last0), .out_valid(out_valid0), .out_ready(out_ready0));

  bit_packer #(.IN_W(8), .OUT_W(32), .MSB_FIRST(1)) u1 (
    .clk(clk), .rst(rst), .in_data(in_data1), .in_bits(in_bits1), .in_valid(in_valid1),
    .in_last(in_last1), .in_ready(in_ready1), .out_data(out_data1), .out_bits(out_bits1),
    .out_last(out_last1), .out_valid(out_valid1), .out_ready(out_ready1));

  int           vectors = 0;
  int           miscompares = 0;
  int           cyc = 0;
  exp_t         sb[2][$];
  logic [255:0] pend[2];
  int           pcnt[2];
  bit           flush_m[2];
  bit           stall_prev[2];
  logic [127:0] prev_data[2];
  int           prev_bits[2];
  bit           prev_last[2];
  logic [127:0] last_word[2];
  int           ordy_mode[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input int k, input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL u%0d %s: got %0h, expected %0h (t=%0t)", k, name, act, exp, $time);
    end
  endtask

  task automatic fail(input int k, input string name);
    vectors++;
    miscompares++;
    $display("FAIL u%0d %s: bound expired (t=%0t)", k, name, $time);
  endtask

  // Reference: the message is a plain ordered list of bits; words are cut from its front.
  task automatic take_word(input int k, input int n, output logic [127:0] w);
    int outw;
    outw = (k == 0) ? 64 : 32;
    w = '0;
    for (int j = 0; j < n; j++) begin
      if (k == 1) w[outw-1-j] = pend[k][j];
      else        w[j]        = pend[k][j];
    end
    pend[k] = pend[k] >> n;
    pcnt[k] = pcnt[k] - n;
  endtask

  task automatic model_push(input int k, input logic [127:0] d, input int b_in, input bit l);
    int inw, outw, b;
    bit emitted;
    logic [127:0] w;
    inw  = (k == 0) ? 64 : 8;
    outw = (k == 0) ? 64 : 32;
    b    = (b_in > inw) ? inw : b_in;
    for (int j = 0; j < b; j++) begin
      pend[k][pcnt[k]] = (k == 1) ? d[b-1-j] : d[j];
      pcnt[k]++;
    end
    emitted = 0;
    while (pcnt[k] >= outw) begin
      take_word(k, outw, w);
      sb[k].push_back('{w, outw, l && (pcnt[k] == 0)});
      emitted = 1;
    end
    if (l && (pcnt[k] > 0 || !emitted)) begin
      b = pcnt[k];
      take_word(k, b, w);
      sb[k].push_back('{w, b, 1'b1});
    end
    if (l) flush_m[k] = 1;
  endtask

  task automatic monitor(input int k, input logic ov, input logic [127:0] od, input int ob,
                         input logic ol, input logic ordy, input logic irdy, input logic iv,
                         input logic [127:0] id, input int ib, input logic il);
    exp_t e;
    if (rst) begin
      check(k, "in_ready_during_rst", irdy, 0);
      sb[k].delete();
      pend[k] = '0;
      pcnt[k] = 0;
      flush_m[k] = 0;
      stall_prev[k] = 0;
    end else begin
      check(k, "out_valid", ov, sb[k].size() > 0);
      if (stall_prev[k]) begin
        check(k, "hold_data", od, prev_data[k]);
        check(k, "hold_bits", ob, prev_bits[k]);
        check(k, "hold_last", ol, prev_last[k]);
      end
      if (ov && !ordy) check(k, "in_ready_stalled", irdy, 0);
      if (!flush_m[k] && ordy) check(k, "in_ready_free", irdy, 1);
      if (ov && ordy && sb[k].size() > 0) begin
        e = sb[k].pop_front();
        check(k, "out_data", od, e.data);
        check(k, "out_bits", ob, e.bits);
        check(k, "out_last", ol, e.last);
        last_word[k] = od;
        if (e.last) flush_m[k] = 0;
      end
      stall_prev[k] = ov && !ordy;
      prev_data[k]  = od;
      prev_bits[k]  = ob;
      prev_last[k]  = ol;
      if (iv && irdy) model_push(k, id, ib, il);
    end
  endtask

  always @(negedge clk) begin
    monitor(0, out_valid0, 128'(out_data0), int'(out_bits0), out_last0, out_ready0, in_ready0,
            in_valid0, 128'(in_data0), int'(in_bits0), in_last0);
    monitor(1, out_valid1, 128'(out_data1), int'(out_bits1), out_last1, out_ready1, in_ready1,
            in_valid1, 128'(in_data1), int'(in_bits1), in_last1);
  end

  always @(posedge clk) begin
    #1;
    out_ready0 = (ordy_mode[0] == 1) ? 1'b1 : (ordy_mode[0] == 2) ? 1'b0 : ($urandom % 4 != 0);
    out_ready1 = (ordy_mode[1] == 1) ? 1'b1 : (ordy_mode[1] == 2) ? 1'b0 : ($urandom % 4 != 0);
  end

  task automatic send(input int k, input logic [127:0] d, input int b, input bit l);
    int  n;
    logic rdy;
    n = 0;
    if (k == 0) begin
      in_data0 = d[63:0]; in_bits0 = 7'(b); in_last0 = l; in_valid0 = 1'b1;
    end else begin
      in_data1 = d[7:0]; in_bits1 = 4'(b); in_last1 = l; in_valid1 = 1'b1;
    end
    do begin
      @(negedge clk);
      n++;
      rdy = (k == 0) ? in_ready0 : in_ready1;
    end while (!rdy && n < 400);
    if (!rdy) fail(k, "send_accept");
    @(posedge clk);
    #1;
    if (k == 0) in_valid0 = 1'b0;
    else        in_valid1 = 1'b0;
  endtask

  task automatic wait_drain(input int k);
    int n;
    n = 0;
    while (sb[k].size() > 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (sb[k].size() > 0) fail(k, "drain");
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a, b;
    int c0;
    rst = 1'b1;
    in_valid0 = 0; in_last0 = 0; in_data0 = '0; in_bits0 = '0; out_ready0 = 0;
    in_valid1 = 0; in_last1 = 0; in_data1 = '0; in_bits1 = '0; out_ready1 = 0;
    ordy_mode[0] = 1;
    ordy_mode[1] = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check(0, "rst_out_valid", out_valid0, 0);
    check(0, "rst_out_bits", out_bits0, 0);
    check(0, "rst_out_last", out_last0, 0);
    check(0, "rst_out_data", out_data0, 0);
    check(1, "rst_out_valid", out_valid1, 0);
    check(1, "rst_out_bits", out_bits1, 0);
    @(posedge clk);
    #1;

    send(1, 128'hA, 4, 0);
    send(1, 128'h5, 4, 1);
    wait_drain(1);
    check(1, "msb_word", last_word[1], 128'hA5000000);

    for (int i = 1; i <= 8; i++) send(0, 128'(i), 8, 0);
    wait_drain(0);
    check(0, "lsb_word", last_word[0], 128'h0807060504030201);

    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    send(0, 128'(a), 40, 0);
    send(0, 128'(b), 40, 0);
    send(0, 128'h0, 0, 1);
    wait_drain(0);
    check(0, "tail_word", last_word[0], 128'(b[39:24]));

    c0 = cyc;
    for (int i = 0; i < 100; i++) send(0, {64'h0, $urandom, $urandom}, 64, 0);
    check(0, "stream_cycles", cyc - c0, 100);
    wait_drain(0);

    ordy_mode[0] = 2;
    repeat (2) @(posedge clk);
    #1;
    send(0, {64'h0, $urandom, $urandom}, 64, 0);
    fork
      send(0, {64'h0, $urandom, $urandom}, 64, 0);
      begin
        repeat (6) @(posedge clk);
        ordy_mode[0] = 1;
      end
    join
    wait_drain(0);

    send(0, 128'h0, 0, 1);
    wait_drain(0);
    check(0, "empty_flush_bits", last_word[0], 0);

    for (int i = 0; i < 3; i++) send(0, 128'($urandom), 8, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check(0, "post_rst_out_valid", out_valid0, 0);
    @(posedge clk);
    #1;
    for (int i = 1; i <= 8; i++) send(0, 128'(8'h10 + i), 8, 0);
    wait_drain(0);
    check(0, "post_rst_word", last_word[0], 128'h1817161514131211);

    ordy_mode[0] = 0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom % 5 == 0) begin
        @(posedge clk);
        #1;
      end
      send(0, {64'h0, $urandom, $urandom}, $urandom_range(0, 90), ($urandom % 10) == 0);
    end
    send(0, 128'h0, $urandom_range(0, 64), 1);
    ordy_mode[0] = 1;
    wait_drain(0);

    ordy_mode[1] = 0;
    for (int i = 0; i < 300; i++)
      send(1, 128'($urandom), $urandom_range(0, 15), ($urandom % 8) == 0);
    send(1, 128'h0, 0, 1);
    ordy_mode[1] = 1;
    wait_drain(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bit_packer.md
Name: bit_packer

Overview:
Parametrised variable-length bit packer and the next generation of the control-path shift-concatenation stage. It packs input fragments of 0..IN_W valid bits into dense OUT_W-bit words. It adds several features: independent input and output widths, valid/ready backpressure on both sides, LSB-first or MSB-first packing order, and an explicit end-of-message flush. The flush emits a partial last word with its bit count. The block sits between the compressor's variable-length code emitter and the fixed-width encryption datapath.

Parameters:
IN_W, 64, input fragment width in bits (1..128)
OUT_W, 64, output word width in bits (8..128)
MSB_FIRST, 0, 0 = first-received bit lands at out_data[0]; 1 = first-received bit lands at out_data[OUT_W-1]
ACC_W (localparam), max(IN_W,OUT_W)+IN_W, accumulator width
CNT_W (localparam), clog2(ACC_W+1), fill counter width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
in_data  in  IN_W  fragment; valid bits in in_data[in_bits-1:0], higher bits ignored (masked)
in_bits  in  clog2(IN_W+1)  valid bit count; values above IN_W are clamped to IN_W
in_valid  in  1  fragment present
in_last  in  1  fragment is the end of the message; flush after it
in_ready  out  1  fragment accepted when in_valid && in_ready
out_data  out  OUT_W  packed word; bits beyond out_bits are zero
out_bits  out  clog2(OUT_W+1)  valid bits in out_data (OUT_W, except on the last word)
out_last  out  1  final word of the message
out_valid  out  1  word present
out_ready  in  1  word consumed when out_valid && out_ready

Behaviour:
- Reset is synchronous and active-high on clk. While rst is high, in_ready=0.
- The first cycle after rst falls has: fill=0, accumulator all-zero, flush_pend=0, out_valid=0, out_bits=0, out_last=0, out_data=0.
- Reset mid-message discards all buffered bits. No partial word is emitted.
- Accumulator invariant: every accumulator bit outside the fill region is zero.
- in_ready = !rst && !flush_pend && (fill < OUT_W || out_ready). The combinational path out_ready->in_ready is intentional. There is no combinational path from in_valid to any output.
- out_valid = (fill >= OUT_W) || flush_pend. It depends on state only.
- Full word: out_bits=OUT_W, out_last = flush_pend && fill==OUT_W.
- Partial word: only when flush_pend && fill<OUT_W. out_bits=fill, out_last=1, zero-padded. For MSB_FIRST=0 the data is right-aligned; for MSB_FIRST=1 it is left-aligned.
- Empty flush: fill==0 && flush_pend gives out_valid=1, out_bits=0, out_data=0, out_last=1. This marks end-of-message downstream.
- Per cycle, let a = in fire, b = out fire:
  - If b: consume OUT_W bits, or fill bits if fill<OUT_W.
  - If a: append in_bits bits after the remaining bits.
  - fill_next = fill - consumed + (a ? in_bits : 0).
- Simultaneous a and b: drain first, then append. ACC_W guarantees no overflow, including the fill=OUT_W+IN_W-1 case.
- in_bits=0 with in_valid: accepted with no data change. If in_last is also set, it still starts the flush.
- in_last accepted: flush_pend sets next cycle and in_ready drops. All buffered words drain, the last one with out_last=1. On that word's fire: flush_pend=0, fill=0, and in_ready returns the next cycle.
- Stability: while out_valid && !out_ready, out_data, out_bits and out_last hold constant. This is guaranteed because input is only accepted below OUT_W fill or with an out fire.
- Latency: the fragment that completes a word is accepted in cycle N; out_valid=1 in cycle N+1.
- Throughput: with out_ready held at 1, in_ready stays 1, so one input per cycle is sustained for any in_bits.
- Ordering: bit order within a fragment is preserved (in_data[0] is the first bit for LSB-first; in_data[in_bits-1] is the first bit for MSB-first).

Decomposition:
- Package bit_packer_pkg holds: a clog2 function, the pack-order constants PACK_LSB=0 and PACK_MSB=1, and a max() function for the ACC_W derivation.
- One sub-module is natural: bp_mask_shift. It is a combinational mask-and-align unit that takes (in_data, in_bits, fill_after_drain, MSB_FIRST) and produces the ACC_W-wide insert vector.
- The top level holds the accumulator, the fill counter, the flush state (IDLE/FLUSH) and the handshakes.

Test Plan:
- IN_W=OUT_W=64, LSB-first:
  - Stimulus: eight 8-bit fragments 0x01..0x08, out_ready=1.
  - Response: one word 0x0807060504030201, out_bits=64, out_valid high the cycle after the 8th accept.
- Two 40-bit fragments A, then B:
  - Response: word = {B[23:0],A[39:0]}, out_last=0, fill=16 remaining.
  - Then in_last with in_bits=0: word = B[39:24] right-aligned, out_bits=16, out_last=1.
- Continuous 64-bit fragments with out_ready=1 for 100 cycles:
  - Response: in_ready never drops, 100 words out, and each word equals its input delayed 1 cycle.
- Backpressure:
  - Stimulus: hold out_ready=0 at fill=64 for 5 cycles.
  - Response: in_ready=0 and out_data/out_bits stable throughout; after release, one word drains per cycle with no loss or duplication.
- MSB_FIRST=1, OUT_W=32:
  - Stimulus: 4-bit 0xA, 4-bit 0x5 with in_last.
  - Response: out_data=0xA5000000, out_bits=8, out_last=1.
- Empty flush and reset:
  - Stimulus: in_last with in_bits=0 on an empty buffer. Response: out_bits=0, out_last=1.
  - Stimulus: assert rst for 1 cycle at fill=24. Response: next cycle out_valid=0, and the next message packs from bit 0.
